// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor/direction constants, response codes and queue entry type
package elevator_pkg;
  localparam int FLOOR_W    = 3;
  localparam int NUM_FLOORS = 8;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam logic [1:0] RESP_NONE    = 2'b00;
  localparam logic [1:0] RESP_STORED  = 2'b01;
  localparam logic [1:0] RESP_MERGED  = 2'b10;
  localparam logic [1:0] RESP_DROPPED = 2'b11;
  typedef struct packed {
    logic               valid;
    logic [FLOOR_W-1:0] floor;
    logic               dir;
  } entry_t;
endpackage

// File: rtl/call_queue_compact.sv
// call_queue_compact: drops removed entries and packs survivors toward entry 0 in order
module call_queue_compact
  import elevator_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  entry_t [DEPTH-1:0]       i_entries,
  input  logic   [DEPTH-1:0]       i_remove,
  output entry_t [DEPTH-1:0]       o_entries,
  output logic   [$clog2(DEPTH):0] o_free_idx
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  // Each surviving entry lands at the running survivor count; unused slots stay zero
  always_comb begin
    o_entries  = '0;
    o_free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_entries[i].valid && !i_remove[i]) begin
        o_entries[o_free_idx[IW-1:0]] = i_entries[i];
        o_free_idx = o_free_idx + CW'(1);
      end
    end
  end
endmodule

// File: rtl/call_queue.sv
// call_queue: ordered, duplicate-free pending hall-call store with per-floor service removal
module call_queue
  import elevator_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic                  call_dir,
  input  logic                  serve_valid,
  input  logic [FLOOR_W-1:0]    serve_floor,
  input  logic                  clear,
  output logic [1:0]            call_resp,
  output logic                  head_valid,
  output logic [FLOOR_W-1:0]    head_floor,
  output logic                  head_dir,
  output logic [NUM_FLOORS-1:0] pending_mask,
  output logic [$clog2(DEPTH):0] count,
  output logic                  full
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  entry_t [DEPTH-1:0] r_q;
  logic   [1:0]       r_resp;
  entry_t [DEPTH-1:0] w_packed;
  entry_t [DEPTH-1:0] w_next;
  logic   [DEPTH-1:0] w_remove;
  logic   [CW-1:0]    w_free;
  logic               w_bad;
  logic               w_dup;
  logic   [1:0]       w_resp;
  logic   [CW-1:0]    w_count;
  logic   [NUM_FLOORS-1:0] w_mask;
  // Mark every valid entry on the served floor, regardless of direction
  always_comb begin
    w_remove = '0;
    for (int i = 0; i < DEPTH; i++)
      w_remove[i] = serve_valid && r_q[i].valid && (r_q[i].floor == serve_floor);
  end
  call_queue_compact #(.DEPTH(DEPTH)) u_compact (
    .i_entries  (r_q),
    .i_remove   (w_remove),
    .o_entries  (w_packed),
    .o_free_idx (w_free)
  );
  // Classify the call against the post-serve queue, then insert it at the first free slot
  always_comb begin
    w_bad = (int'(call_floor) >= NUM_FLOORS)
         || (call_dir == DIR_UP   && call_floor == FLOOR_W'(NUM_FLOORS - 1))
         || (call_dir == DIR_DOWN && call_floor == '0);
    w_dup = serve_valid && (call_floor == serve_floor);
    for (int i = 0; i < DEPTH; i++)
      if (w_packed[i].valid && w_packed[i].floor == call_floor && w_packed[i].dir == call_dir) w_dup = 1'b1;
    w_resp = !call_valid               ? RESP_NONE
           : (clear || w_bad)          ? RESP_DROPPED
           : w_dup                     ? RESP_MERGED
           : (w_free == CW'(DEPTH))    ? RESP_DROPPED
           :                             RESP_STORED;
    w_next = w_packed;
    if (w_resp == RESP_STORED) w_next[w_free[IW-1:0]] = '{valid: 1'b1, floor: call_floor, dir: call_dir};
    if (clear) w_next = '0;
  end
  // Queue state and the one-cycle call response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_resp <= RESP_NONE;
    end else begin
      r_q    <= w_next;
      r_resp <= w_resp;
    end
  end
  // Occupancy and per-floor pending bits decoded from registered entries
  always_comb begin
    w_count = '0;
    w_mask  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + CW'(r_q[i].valid);
      if (r_q[i].valid) w_mask[r_q[i].floor] = 1'b1;
    end
  end
  assign call_resp    = r_resp;
  assign head_valid   = r_q[0].valid;
  assign head_floor   = r_q[0].valid ? r_q[0].floor : '0;
  assign head_dir     = r_q[0].valid & r_q[0].dir;
  assign pending_mask = w_mask;
  assign count        = w_count;
  assign full         = (w_count == CW'(DEPTH));
endmodule
